cache_dm_ctrl: RTL

Parametrised direct-mapped, write-through, no-write-allocate cache controller sitting between the CPU load/store port and main memory. It replaces the fixed single-width cache top with configurable line count and words-per-line, a registered request/ready CPU handshake, and a multi-beat request/acknowledge memory interface. Line refill is a burst of single-word beats. A compile-time option adds hit/miss counters.

---
 rtl/cache_dm_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cache_dm_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with burst line refill.
// Define CACHE_STATS_EN to add saturating HIT_CNT / MISS_CNT lookup counters.
module cache_dm_ctrl #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int INDEX_BITS = 4,
    parameter int WORD_BITS  = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ,
    input  logic          WE,
    input  logic [AW-1:0] AB,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT,
    output logic          READY,
    output logic          BUSY,
    output logic          M_REQ,
    output logic          M_WE,
    output logic [AW-1:0] M_AB,
    output logic [DW-1:0] M_DOUT,
    input  logic [DW-1:0] M_DIN,
    input  logic          M_ACK
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]   HIT_CNT,
    output logic [31:0]   MISS_CNT
`endif
);
    localparam int TAG_BITS = AW - INDEX_BITS - WORD_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << WORD_BITS;
    localparam int TAG_LSB  = INDEX_BITS + WORD_BITS + 2;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [AW-1:2]           r_addr;
    logic                    r_we;
    logic [DW-1:0]           r_din;
    logic [WORD_BITS-1:0]    r_beat;
    logic [DW-1:0]           r_dout;
    logic                    r_ready;
    logic [LINES-1:0]        r_valid;
    logic [TAG_BITS-1:0]     r_tag  [LINES];
    logic [DW-1:0]           r_data [LINES*WORDS];

    logic [TAG_BITS-1:0]     w_tag;
    logic [INDEX_BITS-1:0]   w_index;
    logic [WORD_BITS-1:0]    w_word;
    logic                    w_hit;
    logic                    w_last_beat;
    logic                    w_unused;

    assign w_tag       = r_addr[AW-1:TAG_LSB];
    assign w_index     = r_addr[TAG_LSB-1:WORD_BITS+2];
    assign w_word      = r_addr[WORD_BITS+1:2];
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_last_beat = &r_beat;
    assign w_unused    = &{1'b0, AB[1:0]};

    assign DOUT  = r_dout;
    assign READY = r_ready;
    assign BUSY  = (r_state != S_IDLE);

    // Memory-side outputs depend only on state and registers, never on M_ACK.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next = r_state;
        M_REQ  = 1'b0;
        M_WE   = 1'b0;
        M_AB   = '0;
        M_DOUT = '0;
        case (r_state)
            S_IDLE: begin
                if (REQ) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_we)       w_next = S_WRITE;
                else if (w_hit) w_next = S_IDLE;
                else            w_next = S_REFILL;
            end
            S_REFILL: begin
                M_REQ = 1'b1;
                M_AB  = {r_addr[AW-1:WORD_BITS+2], r_beat, 2'b00};
                if (M_ACK && w_last_beat) w_next = S_IDLE;
            end
            S_WRITE: begin
                M_REQ  = 1'b1;
                M_WE   = 1'b1;
                M_AB   = {r_addr, 2'b00};
                M_DOUT = r_din;
                if (M_ACK) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_din   <= '0;
            r_beat  <= '0;
            r_dout  <= '0;
            r_ready <= 1'b0;
            r_valid <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_addr <= AB[AW-1:2];
                        r_we   <= WE;
                        r_din  <= DIN;
                    end
                end
                S_LOOKUP: begin
                    if (!r_we && w_hit) begin
                        r_dout  <= r_data[{w_index, w_word}];
                        r_ready <= 1'b1;
                    end else if (!r_we) begin
                        r_beat <= '0;
                    end
                end
                S_REFILL: begin
                    if (M_ACK) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_valid[w_index] <= 1'b1;
                            // Earlier beats are already in the array; the last one is still on M_DIN.
                            r_dout  <= (w_word == r_beat) ? M_DIN : r_data[{w_index, w_word}];
                            r_ready <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (M_ACK) r_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: data and tag arrays carry no reset; the valid bits alone decide what is meaningful.
    always_ff @(posedge CLK) begin
        if (r_state == S_LOOKUP && r_we && w_hit) begin
            r_data[{w_index, w_word}] <= r_din;
        end
        if (r_state == S_REFILL && M_ACK) begin
            r_data[{w_index, r_beat}] <= M_DIN;
            if (w_last_beat) r_tag[w_index] <= w_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit && r_hit_cnt != 32'hFFFF_FFFF)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (!w_hit && r_miss_cnt != 32'hFFFF_FFFF)
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign HIT_CNT  = r_hit_cnt;
    assign MISS_CNT = r_miss_cnt;
`endif

endmodule
